// File: rtl/dec_arb_ctrl.sv
// Two-requester round-robin front end for a shared syndrome unit, with error classification.
// Optional DEC_ARB_CTRL_ERR_CNT_EN adds saturating single/double error counters.
module dec_arb_ctrl #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26,
  localparam int unsigned PW                = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0_valid,
  input  logic [MAX_CODEWORD_WIDTH-1:0] req0_data,
  input  logic [1:0]                    req0_mode,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [MAX_CODEWORD_WIDTH-1:0] req1_data,
  input  logic [1:0]                    req1_mode,
  output logic                          req1_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] mult_data,
  output logic [1:0]                    mult_mode,
  input  logic [PW-1:0]                 mult_syndrome,
  output logic                          res_valid,
  output logic                          res_id,
  output logic [PW-1:0]                 res_syndrome,
  output logic [1:0]                    res_err,
  input  logic                          res_ready
`ifdef DEC_ARB_CTRL_ERR_CNT_EN
  ,
  output logic [15:0]                   cnt_single,
  output logic [15:0]                   cnt_double
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  localparam logic [1:0] ModeIllegal = 2'b11;

  state_e                          state_q, state_d;
  logic                            ptr_q;
  logic                            grant0, grant1, grant_any;
  logic [MAX_CODEWORD_WIDTH-1:0]   gnt_data;
  logic [1:0]                      gnt_mode;
  logic                            parity_bit;
  logic [1:0]                      err_class;
  logic                            done;

  // Pointer names the preferred requester; a lone requester always wins.
  always_comb begin
    grant0    = req0_valid & (~req1_valid | ~ptr_q);
    grant1    = req1_valid & (~req0_valid | ptr_q);
    grant_any = (state_q == StIdle) & (req0_valid | req1_valid);
    gnt_data  = grant1 ? req1_data : req0_data;
    gnt_mode  = grant1 ? req1_mode : req0_mode;
  end

  // Parity bit position depends on the code size of the latched mode.
  always_comb begin
    int sel;
    parity_bit = 1'b0;
    unique case (mult_mode)
      2'b00:   sel = 3;
      2'b01:   sel = 4;
      default: sel = 5;
    endcase
    for (int i = 0; i < int'(PW); i++) begin
      if (i == sel) parity_bit = mult_syndrome[i];
    end
    if (mult_syndrome == '0) err_class = 2'b00;
    else if (parity_bit)     err_class = 2'b01;
    else                     err_class = 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req0_valid | req1_valid) begin
          state_d = (gnt_mode == ModeIllegal) ? StResp : StIssue;
        end
      end
      StIssue:   state_d = StCapture;
      StCapture: state_d = StResp;
      StResp:    if (res_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == StIdle) & grant0;
    req1_ready = (state_q == StIdle) & grant1;
    res_valid  = (state_q == StResp);
  end

  assign done = (state_q == StResp) & res_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= 1'b0;
      mult_data    <= '0;
      mult_mode    <= 2'b00;
      res_id       <= 1'b0;
      res_syndrome <= '0;
      res_err      <= 2'b00;
    end else begin
      if (grant_any) begin
        mult_data <= gnt_data;
        mult_mode <= gnt_mode;
        res_id    <= grant1;
        ptr_q     <= ~grant1;
        if (gnt_mode == ModeIllegal) begin
          res_syndrome <= '0;
          res_err      <= ModeIllegal;
        end
      end
      if (state_q == StCapture) begin
        res_syndrome <= mult_syndrome;
        res_err      <= err_class;
      end
    end
  end

`ifdef DEC_ARB_CTRL_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_single <= '0;
      cnt_double <= '0;
    end else if (done) begin
      if (res_err == 2'b01 && cnt_single != 16'hFFFF) cnt_single <= cnt_single + 16'd1;
      if (res_err == 2'b10 && cnt_double != 16'hFFFF) cnt_double <= cnt_double + 16'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_dec_arb_ctrl.sv
// Directed bench for dec_arb_ctrl: vector table plus hand-written multi-cycle sequences.
// Define DEC_ARB_CTRL_ERR_CNT_EN to also exercise the error counters.
module tb_dec_arb_ctrl;

  localparam int CW = 32;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [CW-1:0] req0_data, req1_data;
  logic [1:0]    req0_mode, req1_mode;
  logic          req0_ready, req1_ready;
  logic [CW-1:0] mult_data;
  logic [1:0]    mult_mode;
  logic [PW-1:0] mult_syndrome;
  logic          res_valid, res_id, res_ready;
  logic [PW-1:0] res_syndrome;
  logic [1:0]    res_err;
`ifdef DEC_ARB_CTRL_ERR_CNT_EN
  logic [15:0]   cnt_single, cnt_double;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in syndrome unit: registered low bits of the codeword.
  always @(posedge clk) mult_syndrome <= mult_data[PW-1:0];

  dec_arb_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_mode     (req0_mode),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_mode     (req1_mode),
    .req1_ready    (req1_ready),
    .mult_data     (mult_data),
    .mult_mode     (mult_mode),
    .mult_syndrome (mult_syndrome),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_syndrome  (res_syndrome),
    .res_err       (res_err),
    .res_ready     (res_ready)
`ifdef DEC_ARB_CTRL_ERR_CNT_EN
    ,
    .cnt_single    (cnt_single),
    .cnt_double    (cnt_double)
`endif
  );

  typedef struct {
    logic          v0;
    logic [1:0]    m0;
    logic [CW-1:0] d0;
    logic          v1;
    logic [1:0]    m1;
    logic [CW-1:0] d1;
    logic          exp_id;
    logic [PW-1:0] exp_syn;
    logic [1:0]    exp_err;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; sampling/driving happens 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output logic id);
    id = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req0_ready | req1_ready) begin
        check("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        id = req1_ready;
        return;
      end
      tick();
    end
    check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    logic id;
    req0_valid = v.v0; req0_mode = v.m0; req0_data = v.d0;
    req1_valid = v.v1; req1_mode = v.m1; req1_data = v.d1;
    res_ready = 1'b1;
    wait_grant(id);
    check("grant_id", {31'd0, id}, {31'd0, v.exp_id});
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("mult_data", mult_data, v.exp_id ? v.d1 : v.d0);
    check("mult_mode", {30'd0, mult_mode}, {30'd0, v.exp_id ? v.m1 : v.m0});
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) tick();
      check("res_valid_lat", {31'd0, res_valid}, {31'd0, c == v.lat});
    end
    check("res_id", {31'd0, res_id}, {31'd0, v.exp_id});
    check("res_syndrome", {26'd0, res_syndrome}, {26'd0, v.exp_syn});
    check("res_err", {30'd0, res_err}, {30'd0, v.exp_err});
    tick();
    check("res_valid_drop", {31'd0, res_valid}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic id;
    vec_t vs;

    vecs[0] = '{1'b1, 2'b10, 32'h0000_0000, 1'b0, 2'b00, 32'h0,        1'b0, 6'h00, 2'b00, 3};
    vecs[1] = '{1'b1, 2'b10, 32'h0000_0025, 1'b0, 2'b00, 32'h0,        1'b0, 6'h25, 2'b01, 3};
    vecs[2] = '{1'b1, 2'b10, 32'h0000_0000, 1'b1, 2'b10, 32'h0000_0005, 1'b1, 6'h05, 2'b10, 3};
    vecs[3] = '{1'b1, 2'b00, 32'h0000_0008, 1'b1, 2'b10, 32'h0000_0001, 1'b0, 6'h08, 2'b01, 3};
    vecs[4] = '{1'b0, 2'b00, 32'h0,        1'b1, 2'b01, 32'h0000_0010, 1'b1, 6'h10, 2'b01, 3};
    vecs[5] = '{1'b0, 2'b00, 32'h0,        1'b1, 2'b01, 32'h0000_000F, 1'b1, 6'h0F, 2'b10, 3};
    vecs[6] = '{1'b1, 2'b11, 32'hFFFF_FFFF, 1'b1, 2'b10, 32'h0000_0000, 1'b0, 6'h00, 2'b11, 1};
    vecs[7] = '{1'b1, 2'b10, 32'h0000_0003, 1'b1, 2'b00, 32'hABCD_0037, 1'b1, 6'h37, 2'b10, 3};

    req0_data = '0; req1_data = '0; req0_mode = 2'b00; req1_mode = 2'b00;
    do_reset();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    check("rst_res_syndrome", {26'd0, res_syndrome}, 32'd0);
    check("rst_res_err", {30'd0, res_err}, 32'd0);
    check("rst_mult_data", mult_data, 32'd0);
    check("rst_mult_mode", {30'd0, mult_mode}, 32'd0);
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Continuous contention from reset: grants must alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_mode = 2'b10; req0_data = 32'h100;
    req1_valid = 1'b1; req1_mode = 2'b10; req1_data = 32'h200;
    res_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(id);
      check("rr_order", {31'd0, id}, g % 2);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) tick();

    // Backpressure: response held stable, no grant while stalled or on completion cycle.
    do_reset();
    req0_valid = 1'b1; req0_mode = 2'b10; req0_data = 32'h25;
    req1_valid = 1'b1; req1_mode = 2'b10; req1_data = 32'h05;
    wait_grant(id);
    check("bp_grant", {31'd0, id}, 32'd0);
    repeat (3) tick();
    check("bp_valid", {31'd0, res_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      check("bp_hold_syn", {26'd0, res_syndrome}, 32'h25);
      check("bp_hold_err", {30'd0, res_err}, 32'd1);
      check("bp_hold_id", {31'd0, res_id}, 32'd0);
      check("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_done_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    tick();
    check("bp_idle_valid", {31'd0, res_valid}, 32'd0);
    check("bp_next_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) tick();

    // Illegal mode goes straight to a held response.
    do_reset();
    req1_valid = 1'b1; req1_mode = 2'b11; req1_data = 32'hDEAD_BEEF;
    wait_grant(id);
    check("ill_grant", {31'd0, id}, 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      check("ill_valid", {31'd0, res_valid}, 32'd1);
      check("ill_err", {30'd0, res_err}, 32'd3);
      check("ill_syn", {26'd0, res_syndrome}, 32'd0);
      check("ill_id", {31'd0, res_id}, 32'd1);
    end
    res_ready = 1'b1;
    tick();
    check("ill_done", {31'd0, res_valid}, 32'd0);

    // Reset in CAPTURE discards the codeword and clears the pointer (left at 1 here).
    req0_valid = 1'b1; req0_mode = 2'b10; req0_data = 32'h21;
    wait_grant(id);
    check("rc_grant", {31'd0, id}, 32'd0);
    tick();
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rc_valid", {31'd0, res_valid}, 32'd0);
    check("rc_mult_data", mult_data, 32'd0);
    check("rc_mult_mode", {30'd0, mult_mode}, 32'd0);
    check("rc_syn", {26'd0, res_syndrome}, 32'd0);
    check("rc_err", {30'd0, res_err}, 32'd0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rc_no_resp", {31'd0, res_valid}, 32'd0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_mode = 2'b10; req1_mode = 2'b10;
    wait_grant(id);
    check("rc_ptr_zero", {31'd0, id}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) tick();

`ifdef DEC_ARB_CTRL_ERR_CNT_EN
    do_reset();
    vs = '{1'b1, 2'b10, 32'h0000_0025, 1'b0, 2'b00, 32'h0, 1'b0, 6'h25, 2'b01, 3};
    repeat (3) run_vec(vs);
    check("cnt_single", {16'd0, cnt_single}, 32'd3);
    check("cnt_double", {16'd0, cnt_double}, 32'd0);
`else
    vs = vecs[0];
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_arb_ctrl.md
DEC_ARB_CTRL -- requirements
Module: dec_arb_ctrl

Interface
REQ-001 SHALL take parameter MAX_CODEWORD_WIDTH, default 32, as the codeword width presented to the shared syndrome unit.
REQ-002 SHALL take parameter MAX_INFO_WIDTH, default 26, and derive PW = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH as the syndrome width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1, the requester has a codeword.
REQ-006 SHALL have ports req0_data/req1_data, input, MAX_CODEWORD_WIDTH, the codeword.
REQ-007 SHALL have ports req0_mode/req1_mode, input, 2, the code select: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal.
REQ-008 SHALL have ports req0_ready/req1_ready, output, 1, the codeword is accepted this cycle.
REQ-009 SHALL have ports mult_data (MAX_CODEWORD_WIDTH) and mult_mode (2), outputs driving the shared syndrome unit.
REQ-010 SHALL have port mult_syndrome, input, PW, the syndrome unit's registered result, one cycle after mult_data/mult_mode.
REQ-011 SHALL have outputs res_valid (1), res_id (1, granted requester), res_syndrome (PW) and res_err (2), plus input res_ready (1).

Function
REQ-012 SHALL implement the FSM IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
REQ-013 In IDLE with any reqN_valid, SHALL grant one requester, pulse its reqN_ready for exactly that cycle, latch data/mode/id, and go to ISSUE.
REQ-014 SHALL never assert both reqN_ready together, and SHALL assert neither outside IDLE.
REQ-015 SHALL arbitrate round-robin: a 1-bit pointer (reset 0) names the preferred requester, and after each grant the pointer moves to the non-granted requester.
REQ-016 SHALL grant a lone valid requester regardless of pointer.
REQ-017 SHALL drive mult_data/mult_mode from the latched registers continuously, and they SHALL change only on a grant.
REQ-018 ISSUE SHALL last one cycle; CAPTURE SHALL sample mult_syndrome into res_syndrome; grant-to-res_valid latency SHALL be 3 cycles.
REQ-019 SHALL classify with p = syndrome bit 3/4/5 for mode 00/01/10:
- syndrome==0 -> res_err=00;
- nonzero with p=1 -> 01 (single);
- nonzero with p=0 -> 10 (double).
REQ-020 An illegal mode (11) SHALL be granted normally, skip ISSUE/CAPTURE, and go straight to RESP with res_syndrome=0 and res_err=11.
REQ-021 In RESP, SHALL hold res_valid=1 and all res_* stable until res_ready=1, then return to IDLE next cycle.
REQ-022 res_valid and res_ready both high SHALL complete the transfer in that cycle, and SHALL NOT grant a new request in that same cycle.
REQ-023 reqN_valid deasserted before grant SHALL leave no state change.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, pointer 0, reqN_ready=0, res_valid=0, res_id=0, res_syndrome=0, res_err=00, mult_data=0, mult_mode=00.
REQ-025 Reset during ISSUE/CAPTURE/RESP SHALL discard the in-flight codeword without producing a response.

Configuration
REQ-026 With macro DEC_ARB_CTRL_ERR_CNT_EN defined, SHALL add two 16-bit outputs, cnt_single and cnt_double, each reset to 0.
REQ-027 Each counter SHALL increment on a completed response (res_valid and res_ready) with res_err 01 or 10 respectively, and SHALL saturate at 16'hFFFF.
REQ-028 Without the macro, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Single request: req0 mode 10, data 32'h0, res_ready=1 -> res_valid 3 cycles after grant, res_id=0, res_syndrome=0, res_err=00.
REQ-030 Contention from reset: both valid, continuous -> grants alternate 0,1,0,1; req1 must not be granted twice in a row.
REQ-031 Error classes with model syndrome 6'b100101 (mode 10) -> res_err=01; 6'b000101 -> 10; mode 00, 6'b001000 -> 01.
REQ-032 Backpressure: res_ready=0 for 5 cycles -> res_* stable, no reqN_ready pulse; res_ready=1 -> IDLE next cycle.
REQ-033 Illegal and reset: req1 mode 11 -> res_err=11, res_syndrome=0 two cycles after grant; rst low in CAPTURE -> res_valid=0, pointer 0, no response.
REQ-034 With DEC_ARB_CTRL_ERR_CNT_EN, three single-error responses -> cnt_single=3, cnt_double=0.
